// File: rtl/mem_noc_arbiter_2to1.sv
// rtl/mem_noc_arbiter_2to1.sv - two-master to one-slave memory NoC arbiter, one transaction in flight
// MEM_NOC_ARB_RR_EN selects round-robin contention; undefined gives fixed priority to RST_PRIO.

package mem_noc_pkg;

   typedef struct packed {
      logic [31:0] req_addr;
      logic [31:0] req_wdata;
      logic [3:0]  req_be;
      logic        req_we;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] resp_rdata;
      logic        resp_err;
      logic        resp_last;
   } mem_resp_t;

endpackage

module mem_noc_arbiter_2to1
   import mem_noc_pkg::*;
#(
   parameter bit RST_PRIO = 1'b0
) (
   input  logic      clk,
   input  logic      rst,

   input  logic      m0_req_valid,
   output logic      m0_req_ready,
   input  mem_req_t  m0_req,
   output logic      m0_resp_valid,
   input  logic      m0_resp_ready,
   output mem_resp_t m0_resp,

   input  logic      m1_req_valid,
   output logic      m1_req_ready,
   input  mem_req_t  m1_req,
   output logic      m1_resp_valid,
   input  logic      m1_resp_ready,
   output mem_resp_t m1_resp,

   output logic      sn_req_valid,
   input  logic      sn_req_ready,
   output mem_req_t  sn_req,
   input  logic      sn_resp_valid,
   output logic      sn_resp_ready,
   input  mem_resp_t sn_resp,
   output logic      sn_tid
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t state;
   logic   gnt_q;
   logic   prio_q;

   logic   in_resp;
   logic   resp_done;
   logic   req_en;
   logic   winner;
   logic   req_hs;

   // Responses only flow while a grant is live; a stray beat in IDLE is stalled.
   assign in_resp       = (state == RESP);
   assign sn_resp_ready = in_resp & (gnt_q ? m1_resp_ready : m0_resp_ready);
   assign m0_resp_valid = in_resp & ~gnt_q & sn_resp_valid;
   assign m1_resp_valid = in_resp &  gnt_q & sn_resp_valid;
   assign m0_resp       = sn_resp;
   assign m1_resp       = sn_resp;

   // Final beat handshake reopens the request path in the same cycle.
   assign resp_done     = sn_resp_valid & sn_resp_ready & sn_resp.resp_last;
   assign req_en        = ~in_resp | resp_done;

   assign winner        = (m0_req_valid & m1_req_valid) ? prio_q : m1_req_valid;
   assign sn_req_valid  = req_en & (m0_req_valid | m1_req_valid);
   assign sn_req        = winner ? m1_req : m0_req;
   assign req_hs        = sn_req_valid & sn_req_ready;
   assign m0_req_ready  = req_hs & ~winner;
   assign m1_req_ready  = req_hs &  winner;
   assign sn_tid        = sn_req_valid ? winner : gnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt_q  <= 1'b0;
         prio_q <= RST_PRIO;
      end else begin
         if (req_hs) begin
            state <= RESP;
            gnt_q <= winner;
`ifdef MEM_NOC_ARB_RR_EN
            prio_q <= ~winner;
`endif
         end else if (resp_done) begin
            state <= IDLE;
         end
      end
   end

endmodule
